execute: RTL and testbench

The execute block is the EX stage of the LEGv8 datapath, sitting between register-read/decode and memory access. It selects the ALU second operand (register or sign-extended immediate) and decodes the ALU operation from `alu_op` and the instruction opcode. It computes the ALU result with its zero flag and the branch target address `pc + (imm << 2)`. All three results are registered on one clock.

---
 rtl/execute_if.sv | 33 +++
 rtl/execute.sv | 81 ++++++++
 tb/tb_execute.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/execute_if.sv
// rtl/execute_if.sv - EX stage operand/result bundle
// Purpose: groups the EX-stage inputs (pc, immediate, register operands,
//          opcode and ALU control) and its registered results.
// Ports (modports):
//   master - drives pc, sign_extended_instr, read_data1, read_data2, opcode,
//            alu_op, alu_src; observes alu_result, zero, branch_alu_result
//   slave  - the execute stage; the reverse directions
interface execute_if #(
    parameter int WORD = 64
);
    logic [WORD-1:0] pc;
    logic [WORD-1:0] sign_extended_instr;
    logic [WORD-1:0] read_data1;
    logic [WORD-1:0] read_data2;
    logic [10:0]     opcode;
    logic [1:0]      alu_op;
    logic            alu_src;
    logic [WORD-1:0] alu_result;
    logic            zero;
    logic [WORD-1:0] branch_alu_result;

    modport master (
        output pc, sign_extended_instr, read_data1, read_data2,
               opcode, alu_op, alu_src,
        input  alu_result, zero, branch_alu_result
    );

    modport slave (
        input  pc, sign_extended_instr, read_data1, read_data2,
               opcode, alu_op, alu_src,
        output alu_result, zero, branch_alu_result
    );
endinterface

// File: rtl/execute.sv
// rtl/execute.sv - LEGv8 EX stage: operand mux, ALU control, ALU, branch adder
// Purpose: selects ALU operand B, decodes the 4-bit ALU control code from
//          alu_op/opcode, computes the ALU result with zero flag and the
//          branch target pc + (imm << 2); all results registered, 1-cycle
//          latency, a new operation every cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears all outputs
//   bus   - execute_if.slave: operands/controls in, registered results out
module execute #(
    parameter int WORD = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    execute_if.slave    bus
);
    localparam logic [3:0] CTRL_AND    = 4'b0000;
    localparam logic [3:0] CTRL_ORR    = 4'b0001;
    localparam logic [3:0] CTRL_ADD    = 4'b0010;
    localparam logic [3:0] CTRL_SUB    = 4'b0110;
    localparam logic [3:0] CTRL_PASS_B = 4'b0111;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    logic [WORD-1:0] operand_a;
    logic [WORD-1:0] operand_b;
    logic [3:0]      alu_ctrl;
    logic [WORD-1:0] alu_value;
    logic [WORD-1:0] branch_target;

    assign operand_a = bus.read_data1;
    assign operand_b = bus.alu_src ? bus.sign_extended_instr : bus.read_data2;

    // Anything not explicitly decoded (unlisted R-type opcodes, the reserved
    // alu_op=11 class) falls back to ADD.
    always_comb begin
        alu_ctrl = CTRL_ADD;
        case (bus.alu_op)
            2'b01: alu_ctrl = CTRL_PASS_B;
            2'b10: begin
                case (bus.opcode)
                    OPC_ADD: alu_ctrl = CTRL_ADD;
                    OPC_SUB: alu_ctrl = CTRL_SUB;
                    OPC_AND: alu_ctrl = CTRL_AND;
                    OPC_ORR: alu_ctrl = CTRL_ORR;
                    default: alu_ctrl = CTRL_ADD;
                endcase
            end
            default: alu_ctrl = CTRL_ADD;
        endcase
    end

    always_comb begin
        alu_value = operand_a + operand_b;
        case (alu_ctrl)
            CTRL_AND:    alu_value = operand_a & operand_b;
            CTRL_ORR:    alu_value = operand_a | operand_b;
            CTRL_SUB:    alu_value = operand_a - operand_b;
            CTRL_PASS_B: alu_value = operand_b;
            default:     alu_value = operand_a + operand_b;
        endcase
    end

    // Word offset to byte offset; top bits shifted out are simply lost.
    assign branch_target = bus.pc + {bus.sign_extended_instr[WORD-3:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_result        <= '0;
            bus.zero              <= 1'b0;
            bus.branch_alu_result <= '0;
        end else begin
            bus.alu_result        <= alu_value;
            bus.zero              <= (alu_value == '0);
            bus.branch_alu_result <= branch_target;
        end
    end
endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - directed self-checking bench for execute
module tb_execute;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    execute_if #(.WORD(64)) bus ();

    execute #(.WORD(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    task automatic set_inputs(input logic [63:0] p, input logic [63:0] imm,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [10:0] op, input logic [1:0] aop,
                              input logic src);
        bus.pc = p;
        bus.sign_extended_instr = imm;
        bus.read_data1 = a;
        bus.read_data2 = b;
        bus.opcode = op;
        bus.alu_op = aop;
        bus.alu_src = src;
    endtask

    task automatic apply(input logic [63:0] p, input logic [63:0] imm,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [10:0] op, input logic [1:0] aop,
                         input logic src);
        @(negedge clk);
        set_inputs(p, imm, a, b, op, aop, src);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        set_inputs(64'd200, 64'h40, 64'd16, 64'd5, 11'd0, 2'b00, 1'b1);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.alu_result !== 64'd0 || bus.zero !== 1'b0 || bus.branch_alu_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_state: got res=%0d zero=%0b br=%0d want 0/0/0",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.alu_result !== 64'd0 || bus.zero !== 1'b0 || bus.branch_alu_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_hold: got res=%0d zero=%0b br=%0d want 0/0/0",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ldur;
        apply(64'd200, 64'h40, 64'd16, 64'd999, 11'b11111000010, 2'b00, 1'b1);
        vectors++;
        if (bus.alu_result !== 64'd80 || bus.zero !== 1'b0 || bus.branch_alu_result !== 64'd456) begin
            miscompares++;
            $display("FAIL ldur: got res=%0d zero=%0b br=%0d want 80/0/456",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
    endtask

    task automatic test_rtype_add_sub;
        apply(64'd0, 64'd0, 64'd10, 64'd20, OP_ADD, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd30 || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL r_add: got res=%0d zero=%0b want 30/0", bus.alu_result, bus.zero);
        end
        apply(64'd0, 64'd0, 64'd30, 64'd30, OP_SUB, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd0 || bus.zero !== 1'b1) begin
            miscompares++;
            $display("FAIL r_sub_zero: got res=%0d zero=%0b want 0/1", bus.alu_result, bus.zero);
        end
        apply(64'd0, 64'd0, 64'd0, 64'd1, OP_SUB, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'hFFFF_FFFF_FFFF_FFFF || bus.zero !== 1'b0) begin
            miscompares++;
            $display("FAIL r_sub_wrap: got res=%h zero=%0b want ffffffffffffffff/0",
                     bus.alu_result, bus.zero);
        end
    endtask

    task automatic test_cbz;
        apply(64'd216, 64'hFFFF_FFFF_FFFF_FFFB, 64'd77, 64'd0, 11'b10110100000, 2'b01, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd0 || bus.zero !== 1'b1 || bus.branch_alu_result !== 64'd196) begin
            miscompares++;
            $display("FAIL cbz_taken: got res=%0d zero=%0b br=%0d want 0/1/196",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
        apply(64'd196, 64'd8, 64'd77, 64'd20, 11'b10110100000, 2'b01, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd20 || bus.zero !== 1'b0 || bus.branch_alu_result !== 64'd228) begin
            miscompares++;
            $display("FAIL cbz_not_taken: got res=%0d zero=%0b br=%0d want 20/0/228",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
    endtask

    task automatic test_branch;
        apply(64'd228, 64'h40, 64'd0, 64'd0, 11'd0, 2'b00, 1'b1);
        vectors++;
        if (bus.branch_alu_result !== 64'd484) begin
            miscompares++;
            $display("FAIL br_fwd: got %0d want 484", bus.branch_alu_result);
        end
        apply(64'd484, 64'hFFFF_FFFF_FFFF_FFC9, 64'd0, 64'd0, 11'd0, 2'b00, 1'b1);
        vectors++;
        if (bus.branch_alu_result !== 64'd264) begin
            miscompares++;
            $display("FAIL br_back: got %0d want 264", bus.branch_alu_result);
        end
        apply(64'hFFFF_FFFF_FFFF_FFF0, 64'd8, 64'd0, 64'd0, 11'd0, 2'b00, 1'b1);
        vectors++;
        if (bus.branch_alu_result !== 64'h10) begin
            miscompares++;
            $display("FAIL br_wrap: got %h want 10", bus.branch_alu_result);
        end
        apply(64'd0, 64'h4000_0000_0000_0001, 64'd0, 64'd0, 11'd0, 2'b00, 1'b1);
        vectors++;
        if (bus.branch_alu_result !== 64'h4) begin
            miscompares++;
            $display("FAIL br_shift_out: got %h want 4", bus.branch_alu_result);
        end
    endtask

    task automatic test_logic_ops;
        apply(64'd0, 64'd0, 64'd30, 64'd0, OP_ORR, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd30) begin
            miscompares++;
            $display("FAIL orr: got %0d want 30", bus.alu_result);
        end
        apply(64'd0, 64'd0, 64'd16, 64'd30, OP_AND, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd16) begin
            miscompares++;
            $display("FAIL and: got %0d want 16", bus.alu_result);
        end
        apply(64'd0, 64'd0, 64'd3, 64'd4, 11'b10001011001, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd7) begin
            miscompares++;
            $display("FAIL unlisted_op: got %0d want 7", bus.alu_result);
        end
        apply(64'd0, 64'd0, 64'd12, 64'd10, OP_AND, 2'b00, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd22) begin
            miscompares++;
            $display("FAIL aluop00_ignores_opcode: got %0d want 22", bus.alu_result);
        end
        apply(64'd0, 64'd0, 64'd12, 64'd10, OP_SUB, 2'b11, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd22) begin
            miscompares++;
            $display("FAIL aluop11_reserved: got %0d want 22", bus.alu_result);
        end
    endtask

    task automatic test_back_to_back;
        apply(64'd100, 64'd1, 64'd5, 64'd6, OP_ADD, 2'b10, 1'b0);
        vectors++;
        if (bus.alu_result !== 64'd11 || bus.branch_alu_result !== 64'd104) begin
            miscompares++;
            $display("FAIL b2b_first: got res=%0d br=%0d want 11/104",
                     bus.alu_result, bus.branch_alu_result);
        end
        apply(64'd100, 64'd2, 64'd9, 64'd6, OP_SUB, 2'b10, 1'b1);
        vectors++;
        if (bus.alu_result !== 64'd7 || bus.branch_alu_result !== 64'd108) begin
            miscompares++;
            $display("FAIL b2b_second: got res=%0d br=%0d want 7/108",
                     bus.alu_result, bus.branch_alu_result);
        end
    endtask

    task automatic test_reset_mid_op;
        apply(64'd200, 64'h40, 64'd16, 64'd0, 11'd0, 2'b00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.alu_result !== 64'd0 || bus.zero !== 1'b0 || bus.branch_alu_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_async: got res=%0d zero=%0b br=%0d want 0/0/0",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.alu_result !== 64'd0 || bus.branch_alu_result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_held: got res=%0d br=%0d want 0/0",
                     bus.alu_result, bus.branch_alu_result);
        end
        @(negedge clk);
        set_inputs(64'd8, 64'd1, 64'd3, 64'd4, OP_ADD, 2'b10, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.alu_result !== 64'd7 || bus.zero !== 1'b0 || bus.branch_alu_result !== 64'd12) begin
            miscompares++;
            $display("FAIL reset_release: got res=%0d zero=%0b br=%0d want 7/0/12",
                     bus.alu_result, bus.zero, bus.branch_alu_result);
        end
    endtask

    initial begin
        test_reset;
        test_ldur;
        test_rtype_add_sub;
        test_cbz;
        test_branch;
        test_logic_ops;
        test_back_to_back;
        test_reset_mid_op;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
